// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: instruction size, default reset PC,
// the buffered {pc, instr} entry type and a small alignment helper.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;
  localparam int INSTR_BYTES  = 4;

  localparam logic [FETCH_ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

  // True when a byte address is not on an instruction boundary.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode handshake: head-of-buffer {pc, instr} with valid/ready.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = FETCH_ADDR_W,
  parameter int DATA_WIDTH    = FETCH_DATA_W
);

  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    out_instr;
  logic [ADDRESS_WIDTH-1:0] out_pc;

  modport master (
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush. Flush dominates push and pop;
// a push into a full FIFO is accepted only when a pop frees a slot
// in the same cycle. Storage is reset to zero so the head is never X.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = FETCH_ADDR_W + FETCH_DATA_W,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next-state for pointers and occupancy; flush empties the buffer outright.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a flushed cycle writes nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the combinational
// instruction memory at pc, and queues {pc, instr} pairs for decode.
// Redirect flushes the queue and reloads an aligned PC; halt only
// stops new fetches so the queue still drains.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = FETCH_ADDR_W,
  parameter int                       DATA_WIDTH    = FETCH_DATA_W,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC),
  parameter int                       FIFO_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_instr,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  input  logic                     halt,
  fetch_if.master                  out_if,
  output logic                     misaligned
);

  localparam int ENTRY_W = ADDRESS_WIDTH + DATA_WIDTH;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic                     misaligned_q, misaligned_d;

  logic                     pop, can_push;
  logic                     fifo_full, fifo_empty;
  logic [CNT_W-1:0]         fifo_count;
  logic [ENTRY_W-1:0]       head_data;

  // The memory sees the PC register directly.
  assign imem_addr  = pc_q;
  assign misaligned = misaligned_q;

  assign out_if.out_valid = ~fifo_empty;
  assign out_if.out_pc    = head_data[ENTRY_W-1:DATA_WIDTH];
  assign out_if.out_instr = head_data[DATA_WIDTH-1:0];

  assign pop      = out_if.out_valid & out_if.out_ready;
  assign can_push = ~halt & ~redirect_valid & (~fifo_full | pop);

  // PC and misaligned-flag next state; redirect wins over sequential fetch.
  always_comb begin
    pc_d         = pc_q;
    misaligned_d = misaligned_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
      if (is_misaligned(redirect_pc[1:0])) misaligned_d = 1'b1;
    end else if (can_push) begin
      pc_d = pc_q + ADDRESS_WIDTH'(INSTR_BYTES);
    end
  end

  // PC and sticky misaligned flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (can_push),
    .push_data ({pc_q, imem_instr}),
    .pop       (pop),
    .flush     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_data (head_data)
  );

  // Occupancy and empty flag must always agree.
  a_count_empty: assert property (@(posedge clk) disable iff (rst)
    fifo_empty == (fifo_count == '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the stimulus script queues the
// {pc, instr} pairs decode is expected to accept, a monitor pops and
// compares on every accepted handshake, and the script also checks
// PC, valid and misaligned at chosen cycles.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  fetch_entry_t sb_q[$];

  fetch_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dec_if ();

  fetch_unit #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .RESET_PC      (32'h0000_0000),
    .FIFO_DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_if         (dec_if),
    .misaligned     (misaligned)
  );

  // Instruction memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)      return 32'h1111_1111;
    else if (a == 32'h4) return 32'h2222_2222;
    else                 return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  assign imem_instr = mem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_entry(input logic [31:0] a);
    fetch_entry_t e;
    e.pc    = a;
    e.instr = mem_word(a);
    sb_q.push_back(e);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    adv();
    adv();
    rst = 1'b0;
  endtask

  task automatic chk_drained(input string name);
    chk(name, 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: every accepted (non-flushed) handshake must match the queue head.
  always @(negedge clk) begin
    if (!rst && dec_if.out_valid && dec_if.out_ready && !redirect_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc %h with no entry expected", dec_if.out_pc);
      end else begin
        fetch_entry_t e;
        e = sb_q.pop_front();
        chk("sb_pc", dec_if.out_pc, e.pc);
        chk("sb_instr", dec_if.out_instr, e.instr);
      end
    end
  end

  // Bound on total run time.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    dec_if.out_ready = 1'b1;

    // Streaming with decode always ready.
    do_reset();
    mid();
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(dec_if.out_valid), 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    chk("rst_out_pc_known", dec_if.out_pc, 32'h0);
    expect_entry(32'h0);
    expect_entry(32'h4);
    adv();
    mid();
    chk("lat_valid", 32'(dec_if.out_valid), 32'd1);
    chk("lat_pc", dec_if.out_pc, 32'h0);
    adv();
    mid();
    chk("stream_pc2", dec_if.out_pc, 32'h4);
    adv();
    dec_if.out_ready = 1'b0;
    mid();
    adv();
    mid();
    chk("full_hold_addr", imem_addr, 32'h10);
    chk_drained("drain_stream");

    // Back-pressure from reset, then release.
    do_reset();
    mid();
    adv();
    mid();
    adv();
    mid();
    chk("bp_addr", imem_addr, 32'h8);
    chk("bp_valid", 32'(dec_if.out_valid), 32'd1);
    chk("bp_head", dec_if.out_pc, 32'h0);
    adv();
    mid();
    chk("bp_hold_pc", dec_if.out_pc, 32'h0);
    chk("bp_hold_instr", dec_if.out_instr, 32'h1111_1111);
    chk("bp_hold_addr", imem_addr, 32'h8);
    expect_entry(32'h0);
    expect_entry(32'h4);
    expect_entry(32'h8);
    adv();
    dec_if.out_ready = 1'b1;
    mid();
    adv();
    mid();
    adv();
    mid();
    chk("bp_nogap_pc", dec_if.out_pc, 32'h8);
    adv();
    dec_if.out_ready = 1'b0;

    // Redirect with a full FIFO and a pop in the same cycle.
    mid();
    adv();
    dec_if.out_ready = 1'b1;
    redirect_valid   = 1'b1;
    redirect_pc      = 32'h40;
    mid();
    adv();
    redirect_valid = 1'b0;
    mid();
    chk("redir_flush_valid", 32'(dec_if.out_valid), 32'd0);
    chk("redir_addr", imem_addr, 32'h40);
    expect_entry(32'h40);
    adv();
    mid();
    chk("redir_first_pc", dec_if.out_pc, 32'h40);
    adv();
    dec_if.out_ready = 1'b0;
    mid();
    expect_entry(32'h44);
    expect_entry(32'h48);
    adv();

    // Halt drains the full FIFO, then fetch resumes from the held PC.
    halt             = 1'b1;
    dec_if.out_ready = 1'b1;
    mid();
    adv();
    mid();
    adv();
    mid();
    chk("halt_empty", 32'(dec_if.out_valid), 32'd0);
    chk("halt_addr", imem_addr, 32'h4C);
    adv();
    mid();
    chk("halt_addr_hold", imem_addr, 32'h4C);
    chk("halt_still_empty", 32'(dec_if.out_valid), 32'd0);
    adv();
    halt = 1'b0;
    mid();
    chk("resume_addr", imem_addr, 32'h4C);
    expect_entry(32'h4C);
    adv();
    mid();
    chk("resume_pc", dec_if.out_pc, 32'h4C);
    adv();
    dec_if.out_ready = 1'b0;
    mid();
    adv();
    chk_drained("drain_halt");

    // Misaligned redirect is sticky; redirect while halted still applies.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    mid();
    adv();
    redirect_pc = 32'h100;
    mid();
    chk("mis_addr", imem_addr, 32'h40);
    chk("mis_flag", 32'(misaligned), 32'd1);
    chk("mis_flush", 32'(dec_if.out_valid), 32'd0);
    adv();
    halt        = 1'b1;
    redirect_pc = 32'h200;
    mid();
    chk("mis_aligned_addr", imem_addr, 32'h100);
    chk("mis_sticky", 32'(misaligned), 32'd1);
    adv();
    redirect_valid = 1'b0;
    mid();
    chk("halt_redir_addr", imem_addr, 32'h200);
    chk("halt_redir_valid", 32'(dec_if.out_valid), 32'd0);
    chk("mis_sticky2", 32'(misaligned), 32'd1);
    adv();
    mid();
    chk("halt_redir_hold", imem_addr, 32'h200);
    adv();
    halt = 1'b0;
    mid();
    adv();
    mid();
    chk("post_halt_valid", 32'(dec_if.out_valid), 32'd1);
    chk("post_halt_pc", dec_if.out_pc, 32'h200);
    chk("post_halt_instr", dec_if.out_instr, 32'hC0DE_0200);
    adv();

    // Reset mid-stream with a full FIFO.
    chk_drained("drain_pre_rst");
    rst = 1'b1;
    mid();
    adv();
    rst = 1'b0;
    mid();
    chk("mrst_valid", 32'(dec_if.out_valid), 32'd0);
    chk("mrst_addr", imem_addr, 32'h0);
    chk("mrst_misaligned", 32'(misaligned), 32'd0);

    // PC wraps past the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    adv();
    redirect_valid = 1'b0;
    mid();
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    adv();
    mid();
    chk("wrap_addr_zero", imem_addr, 32'h0);
    chk("wrap_out_pc", dec_if.out_pc, 32'hFFFF_FFFC);
    chk("wrap_out_instr", dec_if.out_instr, 32'hC0DE_FFFC);
    chk_drained("drain_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage; owns the program counter.
- Drives the byte address into the combinational instruction memory and captures the returned 32-bit word the same cycle.
- Buffers {pc, instr} pairs in a small FIFO that feeds the decode stage over a valid/ready handshake.
- Supports redirect (branch/jump) with flush and a halt input that freezes fetch.

Parameters:
ADDRESS_WIDTH, 32, width of PC and memory address
DATA_WIDTH, 32, instruction word width
RESET_PC, 32'h0000_0000, PC value loaded on reset
FIFO_DEPTH, 2, fetch buffer entries (power of two, >=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
imem_addr  output  ADDRESS_WIDTH  byte address to instruction memory (= pc)
imem_instr  input  DATA_WIDTH  word returned combinationally for imem_addr
redirect_valid  input  1  load new PC and flush buffer this cycle
redirect_pc  input  ADDRESS_WIDTH  redirect target
halt  input  1  suppress new fetches while high
out_valid  output  1  buffer head valid
out_ready  input  1  decode accepts head
out_instr  output  DATA_WIDTH  head instruction
out_pc  output  ADDRESS_WIDTH  head PC
misaligned  output  1  sticky: redirect target had nonzero bits [1:0]

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_PC, FIFO emptied (count 0, pointers 0), misaligned<=0. During/after reset, out_valid=0 and imem_addr=RESET_PC. out_instr/out_pc are don't-care when out_valid=0 but must not be X after reset (drive storage reset to 0).
- imem_addr is combinational = pc. No other logic sits between the pc register and memory.
- pop = out_valid & out_ready.
- can_push = !halt & !redirect_valid & (count < FIFO_DEPTH | pop).
- On a push: write {pc, imem_instr} at the tail and set pc<=pc+4. PC addition wraps modulo 2^ADDRESS_WIDTH.
- No push: pc holds.
- Latency: an instruction at address A, presented with an empty FIFO, appears at out_* one cycle after imem_addr=A. Sustained throughput is 1 instr/cycle when out_ready stays high.
- Full FIFO with simultaneous pop: push allowed, count unchanged.
- Empty FIFO: out_valid=0. No bypass of imem_instr to the output; it always goes through the register stage.
- Redirect priority: rst > redirect > push/pop.
- When redirect_valid=1:
  - FIFO flushed (count<=0); any pop that cycle is still visible to decode but its effect is discarded.
  - pc<=redirect_pc with bits [1:0] forced to 0.
  - If redirect_pc[1:0]!=0, misaligned<=1 (sticky until rst).
  - No push that cycle.
- Halt:
  - halt=1 blocks pushes only; pops continue, so the FIFO drains.
  - Redirect while halted still updates pc and flushes.
  - Deassertion resumes fetch from the held pc next cycle.
- FIFO contents and ordering: strict in-order; out_pc of consecutive entries differs by 4 unless separated by a redirect.
- count width: clog2(FIFO_DEPTH)+1. Read/write pointers wrap modulo FIFO_DEPTH.
- Handshake rule: once out_valid=1 without a pop, out_valid/out_instr/out_pc hold stable next cycle unless redirect or rst occurs.

Decomposition:
- Package fetch_pkg holds:
  - INSTR_BYTES=4
  - default RESET_PC
  - typedef fetch_entry_t = struct {pc[ADDRESS_WIDTH-1:0], instr[DATA_WIDTH-1:0]}
- Sub-module fetch_fifo implements a generic synchronous FIFO:
  - ports: push, push_data, pop, flush, full, empty, count, head_data
  - flush dominates push/pop
- fetch_unit contains the PC register, push/redirect control and the misaligned flag, and instantiates fetch_fifo.

Test Plan:
- Reset then out_ready=1, memory words 0x11111111@0, 0x22222222@4 -> imem_addr 0 at reset; cycle 1 out_valid=1, out_pc=0, out_instr=0x11111111; cycle 2 out_pc=4, out_instr=0x22222222.
- out_ready=0 from reset -> two pushes (pc 0, 4), then imem_addr holds 8 with count=2. Raise out_ready -> entries pop in order 0, 4, then pc 8 follows with no gap.
- FIFO full with out_ready=1 and redirect_valid=1, redirect_pc=0x40 -> next cycle out_valid=0, imem_addr=0x40. Following cycle out_pc=0x40.
- halt=1 with 2 entries and out_ready=1 -> both drain over 2 cycles, then out_valid=0 and imem_addr constant. halt=0 -> fetch resumes at the held pc.
- redirect_pc=0x43 -> imem_addr=0x40 next cycle, misaligned=1 and stays 1 through further redirects. rst clears it.
- rst asserted mid-stream with FIFO full -> next cycle out_valid=0, imem_addr=RESET_PC, misaligned=0.
